// File: rtl/avr_pkg.sv
// Shared types and defaults for the AVR data-memory stage: address regions,
// external-bus FSM states and the region decoder.
package avr_pkg;

    typedef enum logic [1:0] {
        RGN_REG  = 2'd0,
        RGN_SRAM = 2'd1,
        RGN_EXT  = 2'd2,
        RGN_HOLE = 2'd3
    } region_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXT_WAIT = 2'd1,
        ST_EXT_DONE = 2'd2
    } dmem_state_e;

    localparam logic [15:0] SRAM_BASE_DEF = 16'h0060;
    localparam logic [15:0] EXT_BASE_DEF  = 16'h8000;

    // sram_end is exclusive and one bit wider so an SRAM ending at 64K still compares correctly.
    function automatic region_e decode_region(input logic [15:0] addr,
                                              input logic [15:0] sram_base,
                                              input logic [16:0] sram_end,
                                              input logic [15:0] ext_base);
        if (addr < sram_base)
            return RGN_REG;
        else if ({1'b0, addr} < sram_end)
            return RGN_SRAM;
        else if (addr >= ext_base)
            return RGN_EXT;
        else
            return RGN_HOLE;
    endfunction

endpackage

// File: rtl/avr_dmem_sram.sv
// Single-port synchronous byte RAM, registered read, write-first on a same-cycle
// read+write. Read data holds when re is low; contents are never reset.
module avr_dmem_sram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we)
            mem[addr] <= wdata;
        if (re)
            rdata <= we ? wdata : mem[addr];
    end

endmodule

// File: rtl/avr_dmem_unit.sv
// Data-memory stage behind the AVR core: decodes REG/SRAM/EXT/HOLE, serves SRAM
// with one-cycle reads and runs the external req/ack bus with a timeout.
module avr_dmem_unit
    import avr_pkg::*;
#(
    parameter logic [15:0] SRAM_BASE  = SRAM_BASE_DEF,
    parameter int          SRAM_DEPTH = 1024,
    parameter logic [15:0] EXT_BASE   = EXT_BASE_DEF,
    parameter int          TIMEOUT    = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] d_addr,
    input  logic [7:0]  d_wdata,
    input  logic        d_write,
    input  logic        d_read,
    output logic [7:0]  d_rdata,
    output logic        mem_stall,
    output logic        ext_req,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    input  logic        ext_ack,
    output logic        bus_err,
    output logic [1:0]  dbg_state
);

    localparam int          AW       = $clog2(SRAM_DEPTH);
    localparam logic [16:0] SRAM_END = {1'b0, SRAM_BASE} + 17'(SRAM_DEPTH);

    dmem_state_e state, state_nxt;
    region_e     region;
    logic        access, ack_hit, expire;
    logic [3:0]  to_cnt;
    logic [7:0]  rdata_q, sram_q;
    logic        src_sram;
    logic        sram_we, sram_re;
    logic [AW-1:0] sram_idx;

    assign region   = decode_region(d_addr, SRAM_BASE, SRAM_END, EXT_BASE);
    // Strobes only count in IDLE: in EXT_WAIT the core is holding them, in EXT_DONE it is dropping them.
    assign access   = (d_read | d_write) && (state == ST_IDLE);
    assign sram_idx = AW'(d_addr - SRAM_BASE);
    assign sram_we  = access && d_write && (region == RGN_SRAM);
    assign sram_re  = access && d_read  && (region == RGN_SRAM);
    assign d_rdata  = src_sram ? sram_q : rdata_q;
    assign dbg_state = state;

    avr_dmem_sram #(.DEPTH(SRAM_DEPTH), .AW(AW)) u_sram (
        .CLK   (CLK),
        .we    (sram_we),
        .re    (sram_re),
        .addr  (sram_idx),
        .wdata (d_wdata),
        .rdata (sram_q)
    );

    always_ff @(posedge CLK) begin
        if (RST)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_stall = 1'b0;
        ack_hit   = 1'b0;
        expire    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access && region == RGN_EXT) begin
                    mem_stall = 1'b1;
                    state_nxt = ST_EXT_WAIT;
                end
            end
            ST_EXT_WAIT: begin
                mem_stall = 1'b1;
                // A late ack on the expiry cycle still completes the access.
                if (ext_ack) begin
                    ack_hit   = 1'b1;
                    state_nxt = ST_EXT_DONE;
                end else if (to_cnt == 4'(TIMEOUT - 1)) begin
                    expire    = 1'b1;
                    state_nxt = ST_EXT_DONE;
                end
            end
            ST_EXT_DONE: state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rdata_q   <= 8'h00;
            src_sram  <= 1'b0;
            ext_req   <= 1'b0;
            ext_we    <= 1'b0;
            ext_addr  <= 16'h0000;
            ext_wdata <= 8'h00;
            bus_err   <= 1'b0;
            to_cnt    <= 4'd0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        case (region)
                            RGN_REG: if (d_read) begin
                                rdata_q  <= 8'h00;
                                src_sram <= 1'b0;
                            end
                            RGN_SRAM: if (d_read) src_sram <= 1'b1;
                            RGN_HOLE: begin
                                bus_err <= 1'b1;
                                if (d_read) begin
                                    rdata_q  <= 8'hFF;
                                    src_sram <= 1'b0;
                                end
                            end
                            RGN_EXT: begin
                                ext_addr  <= d_addr;
                                ext_wdata <= d_wdata;
                                ext_we    <= d_write;
                                ext_req   <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_EXT_WAIT: begin
                    to_cnt <= to_cnt + 4'd1;
                    if (ack_hit) begin
                        ext_req <= 1'b0;
                        if (!ext_we) begin
                            rdata_q  <= ext_rdata;
                            src_sram <= 1'b0;
                        end
                    end else if (expire) begin
                        ext_req <= 1'b0;
                        bus_err <= 1'b1;
                        if (!ext_we) begin
                            rdata_q  <= 8'hFF;
                            src_sram <= 1'b0;
                        end
                    end
                end
                ST_EXT_DONE: to_cnt <= 4'd0;
                default:     to_cnt <= 4'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_avr_dmem_unit.sv
// Self-checking bench for avr_dmem_unit: SRAM, REG, HOLE and external-bus
// accesses with a read-data scoreboard and a reference byte-array model.
module tb_avr_dmem_unit;
    import avr_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] d_addr = 16'h0000;
    logic [7:0]  d_wdata = 8'h00;
    logic        d_write = 1'b0;
    logic        d_read = 1'b0;
    logic [7:0]  d_rdata;
    logic        mem_stall;
    logic        ext_req;
    logic        ext_we;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata = 8'h00;
    logic        ext_ack = 1'b0;
    logic        bus_err;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model [1024];

    avr_dmem_unit dut (
        .CLK       (CLK),
        .RST       (RST),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_write   (d_write),
        .d_read    (d_read),
        .d_rdata   (d_rdata),
        .mem_stall (mem_stall),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_rdata (ext_rdata),
        .ext_ack   (ext_ack),
        .bus_err   (bus_err),
        .dbg_state (dbg_state)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_q_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, {24'd0, d_rdata}, {24'd0, e});
        end
    endtask

    // SRAM / REG / HOLE access: strobes for one cycle, read data popped next cycle.
    task automatic cpu_access(input logic [15:0] a, input logic rd, input logic wr,
                              input logic [7:0] wd, input logic exp_err, input string tag);
        d_addr = a; d_wdata = wd; d_read = rd; d_write = wr;
        #1;
        check({tag, "_stall"}, {31'd0, mem_stall}, 32'd0);
        tick();
        d_read = 1'b0; d_write = 1'b0;
        if (rd) pop_check({tag, "_rdata"});
        check({tag, "_bus_err"}, {31'd0, bus_err}, {31'd0, exp_err});
    endtask

    task automatic sram_write(input logic [15:0] a, input logic [7:0] wd);
        model[a - 16'h0060] = wd;
        cpu_access(a, 1'b0, 1'b1, wd, 1'b0, "sram_wr");
    endtask

    task automatic sram_read(input logic [15:0] a, input string tag);
        exp_q.push_back(model[a - 16'h0060]);
        cpu_access(a, 1'b1, 1'b0, 8'h00, 1'b0, tag);
    endtask

    // External access; ack_dly counts cycles after ext_req rises, negative means no ack.
    task automatic ext_access(input logic [15:0] a, input logic rd, input logic wr,
                              input logic [7:0] wd, input int ack_dly,
                              input logic [7:0] ack_data, input string tag);
        int cyc;
        int stalls;
        int err_seen;
        logic is_wr;
        logic timeout;
        is_wr = wr;
        timeout = (ack_dly < 0);
        if (!is_wr) exp_q.push_back(timeout ? 8'hFF : ack_data);
        d_addr = a; d_wdata = wd; d_read = rd; d_write = wr;
        #1;
        check({tag, "_stall_c0"}, {31'd0, mem_stall}, 32'd1);
        stalls = 1;
        err_seen = 0;
        cyc = 1;
        tick();
        check({tag, "_req"}, {31'd0, ext_req}, 32'd1);
        check({tag, "_addr"}, {16'd0, ext_addr}, {16'd0, a});
        check({tag, "_we"}, {31'd0, ext_we}, {31'd0, is_wr});
        if (is_wr) check({tag, "_wdata"}, {24'd0, ext_wdata}, {24'd0, wd});
        while (cyc < 40) begin
            if (!mem_stall) break;
            stalls++;
            if (bus_err) err_seen++;
            if (!timeout && cyc == 1 + ack_dly) begin
                ext_ack = 1'b1;
                ext_rdata = ack_data;
            end
            tick();
            ext_ack = 1'b0;
            ext_rdata = 8'h00;
            cyc++;
        end
        check({tag, "_bound"}, {31'd0, mem_stall}, 32'd0);
        d_read = 1'b0; d_write = 1'b0;
        check({tag, "_stall_cycles"}, stalls, timeout ? 32'(1 + 15) : 32'(ack_dly + 2));
        check({tag, "_early_err"}, err_seen, 32'd0);
        check({tag, "_req_low"}, {31'd0, ext_req}, 32'd0);
        check({tag, "_bus_err"}, {31'd0, bus_err}, {31'd0, timeout});
        if (!is_wr) pop_check({tag, "_rdata"});
        tick();
        check({tag, "_idle"}, {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check({tag, "_err_once"}, {31'd0, bus_err}, 32'd0);
    endtask

    initial begin
        logic [7:0] last;
        // Reset state
        repeat (3) tick();
        check("rst_rdata", {24'd0, d_rdata}, 32'd0);
        check("rst_stall", {31'd0, mem_stall}, 32'd0);
        check("rst_req", {31'd0, ext_req}, 32'd0);
        check("rst_we", {31'd0, ext_we}, 32'd0);
        check("rst_addr", {16'd0, ext_addr}, 32'd0);
        check("rst_wdata", {24'd0, ext_wdata}, 32'd0);
        check("rst_err", {31'd0, bus_err}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        RST = 1'b0;
        tick();

        // Directed SRAM write/read, then hold
        sram_write(16'h0100, 8'hA5);
        sram_read(16'h0100, "sram_a5");
        tick();
        check("rdata_hold", {24'd0, d_rdata}, 32'hA5);

        // Same-cycle read+write is write-first
        model[0] = 8'h3C;
        exp_q.push_back(8'h3C);
        cpu_access(16'h0060, 1'b1, 1'b1, 8'h3C, 1'b0, "sram_rw_first");

        // SRAM edges and the bytes just outside
        sram_write(16'h045F, 8'h9E);
        sram_read(16'h045F, "sram_top");
        sram_read(16'h0060, "sram_bottom");
        exp_q.push_back(8'hFF);
        cpu_access(16'h0460, 1'b1, 1'b0, 8'h00, 1'b1, "past_top");
        exp_q.push_back(8'h00);
        cpu_access(16'h005F, 1'b1, 1'b0, 8'h00, 1'b0, "below_bottom");
        exp_q.push_back(8'hFF);
        cpu_access(16'h7FFF, 1'b1, 1'b0, 8'h00, 1'b1, "hole_top");
        check("hole_err_pulse", {31'd0, bus_err}, 32'd1);
        tick();
        check("hole_err_clear", {31'd0, bus_err}, 32'd0);
        cpu_access(16'h0010, 1'b0, 1'b1, 8'h77, 1'b0, "reg_wr");

        // Fill SRAM with random bytes, poke the hole, read everything back
        for (int i = 0; i < 1024; i++)
            sram_write(16'(16'h0060 + i), 8'($urandom_range(0, 255)));
        exp_q.push_back(8'hFF);
        cpu_access(16'h0500, 1'b1, 1'b0, 8'h00, 1'b1, "hole_rd");
        cpu_access(16'h0500, 1'b0, 1'b1, 8'h11, 1'b1, "hole_wr");
        for (int i = 0; i < 1024; i++)
            sram_read(16'(16'h0060 + i), "sram_sweep");

        // External bus
        ext_access(16'h8010, 1'b1, 1'b0, 8'h00, 3, 8'h5A, "ext_rd_ack3");
        ext_access(16'h8000, 1'b1, 1'b0, 8'h00, 0, 8'hC3, "ext_rd_ack0");
        ext_access(16'hC000, 1'b1, 1'b0, 8'h00, -1, 8'h00, "ext_rd_timeout");
        ext_access(16'hFFFF, 1'b1, 1'b0, 8'h00, 14, 8'h6D, "ext_ack_at_expiry");
        for (int k = 0; k < 3; k++)
            ext_access(16'($urandom_range(16'h8000, 16'hFFFF)), 1'b1, 1'b0, 8'h00,
                       $urandom_range(0, 10), 8'($urandom_range(0, 255)), "ext_rd_rand");
        last = 8'h00;
        exp_q.push_back(8'h00);
        cpu_access(16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, "reg_rd");
        ext_access(16'hA000, 1'b0, 1'b1, 8'hE7, 2, 8'h99, "ext_wr");
        check("ext_wr_no_rdata", {24'd0, d_rdata}, {24'd0, last});
        ext_access(16'hB000, 1'b1, 1'b1, 8'h2B, 1, 8'h44, "ext_rw_as_wr");
        check("ext_rw_no_rdata", {24'd0, d_rdata}, {24'd0, last});
        ext_access(16'hA001, 1'b0, 1'b1, 8'h12, -1, 8'h00, "ext_wr_timeout");

        // Stray ack while idle
        ext_ack = 1'b1; ext_rdata = 8'hAB;
        tick();
        ext_ack = 1'b0;
        tick();
        check("stray_ack_rdata", {24'd0, d_rdata}, {24'd0, last});
        check("stray_ack_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});

        // Reset in the middle of an external write
        d_addr = 16'h9000; d_wdata = 8'h42; d_write = 1'b1;
        tick();
        check("rst_mid_req_up", {31'd0, ext_req}, 32'd1);
        tick();
        RST = 1'b1; d_write = 1'b0;
        tick();
        check("rst_mid_req", {31'd0, ext_req}, 32'd0);
        check("rst_mid_stall", {31'd0, mem_stall}, 32'd0);
        check("rst_mid_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        RST = 1'b0;
        ext_ack = 1'b1; ext_rdata = 8'h77;
        tick();
        ext_ack = 1'b0;
        tick();
        check("late_ack_rdata", {24'd0, d_rdata}, 32'd0);
        check("late_ack_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("late_ack_req", {31'd0, ext_req}, 32'd0);
        check("late_ack_err", {31'd0, bus_err}, 32'd0);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/avr_dmem_unit.md
Name: avr_dmem_unit

Overview:
- Data-memory stage directly downstream of the AVR CPU core's data port. Consumes the core's data address, write data, write strobe and read strobe, and returns read data.
- Decodes the 16-bit data address into three regions: register/IO shadow space, internal SRAM and an external 8-bit bus.
- Internal SRAM responds with fixed one-cycle read latency. External accesses run a req/ack handshake with a timeout and hold the core with mem_stall until they complete.

Parameters:
- SRAM_BASE, 16'h0060, first internal SRAM byte address.
- SRAM_DEPTH, 1024, internal SRAM size in bytes (power of two).
- EXT_BASE, 16'h8000, first external-bus address; the external region runs EXT_BASE..16'hFFFF.
- TIMEOUT, 15, maximum cycles spent in EXT_WAIT before abort (range 1..15).

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- d_addr  in  16  byte address from core
- d_wdata  in  8  write data from core
- d_write  in  1  write strobe, one cycle per byte
- d_read  in  1  read strobe, one cycle per byte
- d_rdata  out  8  read data to core
- mem_stall  out  1  core must hold d_addr/d_wdata/strobes while high
- ext_req  out  1  external-bus request
- ext_we  out  1  external write (1) / read (0)
- ext_addr  out  16  external address
- ext_wdata  out  8  external write data
- ext_rdata  in  8  external read data, valid with ext_ack
- ext_ack  in  1  external completion, single-cycle pulse
- bus_err  out  1  one-cycle pulse on decode error or timeout

Behaviour:
Reset:
- RST synchronous, active-high; clock CLK.
- On reset: d_rdata=8'h00, mem_stall=0, ext_req=0, ext_we=0, ext_addr=0, ext_wdata=0, bus_err=0, FSM=IDLE, timeout counter=0.
- SRAM contents are not cleared.

Decode (combinational on d_addr):
- REG: addr < SRAM_BASE.
- SRAM: SRAM_BASE <= addr < SRAM_BASE+SRAM_DEPTH.
- EXT: addr >= EXT_BASE.
- HOLE: everything else.

REG region:
- Reads return 8'h00 next cycle; writes are ignored. The core serves this space itself.

SRAM region:
- Index = addr - SRAM_BASE, truncated to log2(SRAM_DEPTH) bits.
- Write commits at the clock edge where d_write=1.
- Read: d_rdata is registered and valid the cycle after d_read=1. No stall.
- d_read and d_write on the same address in the same cycle: write-first, so d_rdata shows the new data.
- d_rdata holds its last value when there is no read.

HOLE region:
- Read returns 8'hFF next cycle; write is dropped.
- bus_err pulses high for one cycle, in the cycle after the access.

EXT region FSM (states IDLE, EXT_WAIT, EXT_DONE):
- IDLE:
  - If (d_read|d_write) and EXT: mem_stall=1 combinationally in that same cycle.
  - Register ext_addr=d_addr, ext_wdata=d_wdata, ext_we=d_write; set ext_req=1 next cycle; go to EXT_WAIT.
- EXT_WAIT:
  - mem_stall=1, ext_req held at 1, counter increments every cycle.
  - On ext_ack: latch ext_rdata into d_rdata (reads only), drop ext_req next cycle, go to EXT_DONE.
  - If counter reaches TIMEOUT with no ack: d_rdata=8'hFF (reads), bus_err pulses once, drop ext_req, go to EXT_DONE.
  - An ack in the same cycle as expiry wins: the access completes normally.
- EXT_DONE:
  - mem_stall=0 so the core consumes d_rdata, counter clears, back to IDLE.
  - Strobes seen in EXT_DONE are ignored; the core deasserts them as stall falls.
- Total EXT latency = ack delay + 2 cycles.

Boundary rules:
- d_read and d_write together on EXT: treated as a write.
- ext_ack outside EXT_WAIT is ignored.
- Reset mid-transaction: ext_req=0 on the next edge, FSM=IDLE, nothing is latched from a late ack.
- SP-style push/pop at the SRAM top and bottom (e.g. 16'h045F and 16'h0060 with defaults) decode to SRAM; one byte past either end decodes to HOLE/REG.

Decomposition:
- Shared package avr_pkg: region enum (REG, SRAM, EXT, HOLE), FSM state encoding, default SRAM_BASE/EXT_BASE constants.
- One sub-module, avr_dmem_sram: single-port synchronous RAM with registered read and write-first behaviour, so a vendor RAM macro can replace it.
- Decode, FSM and timeout counter stay in the top module.

Test Plan:
- Write 8'hA5 to 16'h0100, then read 16'h0100 -> d_rdata=8'hA5 one cycle after d_read; mem_stall stays 0 throughout.
- Same-cycle read+write of 8'h3C at 16'h0060 -> next-cycle d_rdata=8'h3C (write-first).
- Read 16'h8010 with ext_ack and ext_rdata=8'h5A arriving 3 cycles after ext_req -> mem_stall high 5 cycles total, d_rdata=8'h5A when stall falls, ext_req low afterwards, bus_err=0.
- Read 16'hC000 with no ack, TIMEOUT=15 -> 15 cycles in EXT_WAIT, one bus_err pulse, d_rdata=8'hFF, FSM returns to IDLE.
- Read 16'h0500 (HOLE) -> d_rdata=8'hFF next cycle, bus_err one-cycle pulse; a write of 8'h11 to 16'h0500 leaves every SRAM location unchanged.
- Assert RST 2 cycles into an EXT write at 16'h9000 -> next edge: ext_req=0, mem_stall=0, FSM=IDLE; an ack arriving after reset has no effect.
